aes_cone_launch_capture: RTL

Sequential launch/capture stage wrapped around one combinational AES timing cone (12 inputs, 1 output). It sits directly upstream and downstream of the cone. It accepts one input vector per valid/ready handshake and holds it stable on the cone inputs. After a programmable settle time it samples the cone output, then presents the result with the launched vector on a valid/ready output. It also counts results and, optionally, folds them into a signature register for silicon-vs-netlist comparison.

---
 rtl/aes_cone_launch_capture.sv | 136 +++++++++++++
 1 files changed

// File: rtl/aes_cone_launch_capture.sv
// Launch/capture wrapper around one combinational AES timing cone: launches a vector,
// waits WAIT_CYC cycles, samples the cone. Optional result signature via `CONE_MISR_EN.
module aes_cone_launch_capture #(
    parameter int WIDTH    = 12,
    parameter int WAIT_CYC = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic [WIDTH-1:0] cone_in,
    input  logic             cone_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [WIDTH-1:0] out_vec,
    output logic [CNT_W-1:0] result_cnt,
    output logic [15:0]      sig,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       launch;
    logic       capture;
    logic       out_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every flop
            // samples the pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        launch     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    launch     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                // Accepting the next vector in the same cycle the result leaves keeps
                // back-to-back launches free of an IDLE bubble.
                in_ready  = out_ready;
                if (out_ready) begin
                    launch     = in_valid;
                    state_next = in_valid ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign out_fire = out_valid & out_ready;
    assign busy     = (state != ST_IDLE);

    // cone_in only moves on a launch, so the cone sees a stable vector for the whole
    // multicycle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cone_in  <= '0;
            wait_cnt <= 4'd0;
            out_bit  <= 1'b0;
            out_vec  <= '0;
        end else begin
            if (launch) begin
                cone_in  <= in_vec;
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (capture) begin
                out_bit <= cone_out;
                out_vec <= cone_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
        end else if (clr) begin
            result_cnt <= '0;
        end else if (out_fire && result_cnt != '1) begin
            result_cnt <= result_cnt + 1'b1;
        end
    end

`ifdef CONE_MISR_EN
    // Galois LFSR over x^16+x^12+x^5+1 with the result bit folded into bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 16'hFFFF;
        end else if (clr) begin
            sig <= 16'hFFFF;
        end else if (out_fire) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, out_bit};
        end
    end
`else
    assign sig = 16'h0000;
`endif

endmodule
